// File: rtl/avalon_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// avalon_rr_arbiter_if
//   Avalon-MM bundle with active-low read_n/write_n, shared by the engine-side
//   ports and the SDRAM-side port of avalon_rr_arbiter.
//
//   Signals
//     chipselect, read_n, write_n   command (read_n/write_n active-low)
//     address    [ADDR_W]           word address
//     byteenable [BE_W]             byte lanes
//     writedata  [DATA_W]           write data
//     waitrequest                   stall from the slave side
//     readdatavalid                 pipelined read beat
//     readdata   [DATA_W]           read data
//
//   Modports
//     master : issues commands (an engine, or the arbiter towards SDRAM)
//     slave  : accepts commands (SDRAM, or the arbiter towards an engine)
// -----------------------------------------------------------------------------
interface avalon_rr_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2
);
  logic              chipselect;
  logic              read_n;
  logic              write_n;
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic              readdatavalid;
  logic [DATA_W-1:0] readdata;

  modport master (
    output chipselect, read_n, write_n, address, byteenable, writedata,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  chipselect, read_n, write_n, address, byteenable, writedata,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/avalon_rr_arbiter.sv
// -----------------------------------------------------------------------------
// avalon_rr_arbiter
//   Round-robin arbiter sharing one 16-bit SDRAM Avalon-MM master port between
//   two layer engines. Transfers are serialised one at a time; accepted reads
//   record their issuer in a small owner FIFO so each returning readdatavalid
//   beat is steered back to the engine that asked for it.
//
//   Ports
//     clk, reset  sole clock; synchronous active-high reset
//     m0, m1      engine-side Avalon-MM ports (arbiter acts as slave)
//     sdram       SDRAM-side Avalon-MM port (arbiter acts as master)
//     err_orphan  sticky: a read beat arrived with no read outstanding
// -----------------------------------------------------------------------------
module avalon_rr_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int BE_W    = 2,
  parameter int MAX_OUT = 4
) (
  input  logic                clk,
  input  logic                reset,
  avalon_rr_arbiter_if.slave  m0,
  avalon_rr_arbiter_if.slave  m1,
  avalon_rr_arbiter_if.master sdram,
  output logic                err_orphan
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic             gnt;
  logic             last;
  logic             fifo [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Granted requester's command, selected by gnt.
  logic              req0, req1, req_gnt;
  logic              g_read, g_write_n;
  logic [ADDR_W-1:0] g_address;
  logic [BE_W-1:0]   g_byteenable;
  logic [DATA_W-1:0] g_writedata;
  logic              busy, block, cs, accept, push, pop;

  assign req0 = m0.chipselect & (~m0.read_n | ~m0.write_n);
  assign req1 = m1.chipselect & (~m1.read_n | ~m1.write_n);

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_gnt      = req0;
    g_read       = ~m0.read_n;
    g_write_n    = m0.write_n;
    g_address    = m0.address;
    g_byteenable = m0.byteenable;
    g_writedata  = m0.writedata;
    if (gnt) begin
      req_gnt      = req1;
      g_read       = ~m1.read_n;
      g_write_n    = m1.write_n;
      g_address    = m1.address;
      g_byteenable = m1.byteenable;
      g_writedata  = m1.writedata;
    end
  end

  assign busy   = (state == BUSY);
  // A read with every owner slot in use must wait for a beat to come back.
  assign block  = g_read & (count == CNT_FULL);
  assign cs     = busy & req_gnt & ~block;
  assign accept = cs & ~sdram.waitrequest;
  assign push   = accept & g_read;
  assign pop    = sdram.readdatavalid & (count != '0);

  // Master side: pass-through while BUSY, idle values otherwise. Both strobes
  // low is a read, so write_n is forced high whenever read_n is low.
  assign sdram.chipselect = cs;
  assign sdram.read_n     = busy ? ~g_read : 1'b1;
  assign sdram.write_n    = busy ? (g_write_n | g_read) : 1'b1;
  assign sdram.address    = busy ? g_address    : '0;
  assign sdram.byteenable = busy ? g_byteenable : '0;
  assign sdram.writedata  = busy ? g_writedata  : '0;

  // Only the granted engine ever sees waitrequest low.
  assign m0.waitrequest = ~(busy & ~gnt) | sdram.waitrequest | block;
  assign m1.waitrequest = ~(busy &  gnt) | sdram.waitrequest | block;

  // Read beats: data fans out to both engines, the FIFO head steers valid.
  assign m0.readdata      = sdram.readdata;
  assign m1.readdata      = sdram.readdata;
  assign m0.readdatavalid = pop & ~fifo[rd_ptr];
  assign m1.readdatavalid = pop &  fifo[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last       <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            gnt   <= ~last;
            last  <= ~last;
            state <= BUSY;
          end else if (req0) begin
            gnt   <= 1'b0;
            state <= BUSY;
          end else if (req1) begin
            gnt   <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Leave on acceptance, or when the engine withdraws its request.
          if (accept || !req_gnt) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);

      if (sdram.readdatavalid && count == '0) err_orphan <= 1'b1;
    end
  end

  // NOTE: the owner FIFO storage is not reset; count and the pointers define
  // which entries are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= gnt;
  end

endmodule

// File: tb/tb_avalon_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_avalon_rr_arbiter
//   Self-checking bench for avalon_rr_arbiter. An in-order SDRAM model returns
//   read beats either after a fixed latency or on demand; every accepted read
//   pushes {owner, data} onto a scoreboard, popped when an engine-side
//   readdatavalid appears. Engine addresses encode the issuer: m1 uses
//   addresses with bit 13 set, m0 never does.
// -----------------------------------------------------------------------------
module tb_avalon_rr_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 16;
  localparam int BE_W    = 2;
  localparam int MAX_OUT = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } pend_t;

  typedef struct {
    bit                owner;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic err_orphan;

  avalon_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m0_bus ();
  avalon_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) m1_bus ();
  avalon_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) sdram_bus ();

  avalon_rr_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m0         (m0_bus),
    .m1         (m1_bus),
    .sdram      (sdram_bus),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard and SDRAM model state.
  pend_t pend_q [$];
  exp_t  exp_q  [$];
  bit    acc_q  [$];
  int    acc_cnt   = 0;
  int    cyc       = 0;
  bit    auto_ret  = 1'b1;
  int    release_n = 0;
  int    orphan_n  = 0;
  int    rdv0_cnt  = 0;
  int    rdv1_cnt  = 0;

  // SDRAM model: returns beats in order, after 3 cycles or on release.
  initial begin : sdram_driver
    pend_t p;
    sdram_bus.readdatavalid = 1'b0;
    sdram_bus.readdata      = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      sdram_bus.readdatavalid = 1'b0;
      sdram_bus.readdata      = '0;
      if (orphan_n > 0) begin
        sdram_bus.readdatavalid = 1'b1;
        sdram_bus.readdata      = DATA_W'($urandom);
        orphan_n--;
      end else if (pend_q.size() > 0 &&
                   (auto_ret ? (pend_q[0].due <= cyc) : (release_n > 0))) begin
        p = pend_q.pop_front();
        sdram_bus.readdatavalid = 1'b1;
        sdram_bus.readdata      = p.data;
        if (!auto_ret) release_n--;
      end
    end
  end

  // Monitor: records accepted commands and scores returned beats.
  bit                mon_owner;
  logic [DATA_W-1:0] mon_data;
  exp_t              mon_e;
  always @(negedge clk) begin
    if (sdram_bus.chipselect === 1'b1 && sdram_bus.waitrequest === 1'b0) begin
      mon_owner = sdram_bus.address[13];
      acc_q.push_back(mon_owner);
      acc_cnt++;
      if (sdram_bus.read_n === 1'b0) begin
        mon_data = DATA_W'($urandom);
        pend_q.push_back('{data: mon_data, due: cyc + 3});
        exp_q.push_back('{owner: mon_owner, data: mon_data});
      end
    end
    if (m0_bus.readdatavalid === 1'b1 || m1_bus.readdatavalid === 1'b1) begin
      check("rdv_one_hot", m0_bus.readdatavalid & m1_bus.readdatavalid, 0);
      check("rdv_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("rdv_owner", m1_bus.readdatavalid, mon_e.owner);
        check("rdv_data", mon_e.owner ? m1_bus.readdata : m0_bus.readdata, mon_e.data);
        if (m1_bus.readdatavalid) rdv1_cnt++;
        else rdv0_cnt++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int port, input bit cs, input bit rn, input bit wn,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    if (port == 0) begin
      m0_bus.chipselect = cs;  m0_bus.read_n = rn;  m0_bus.write_n = wn;
      m0_bus.address    = addr; m0_bus.writedata = wd;
      m0_bus.byteenable = cs ? '1 : '0;
    end else begin
      m1_bus.chipselect = cs;  m1_bus.read_n = rn;  m1_bus.write_n = wn;
      m1_bus.address    = addr; m1_bus.writedata = wd;
      m1_bus.byteenable = cs ? '1 : '0;
    end
  endtask

  function automatic logic wait_of(input int port);
    return (port == 0) ? m0_bus.waitrequest : m1_bus.waitrequest;
  endfunction

  // Engine model: hold the command until waitrequest is seen low.
  task automatic xfer(input int port, input bit rd, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] wd);
    int guard = 0;
    drive(port, 1'b1, !rd, rd, addr, wd);
    forever begin
      @(negedge clk);
      if (wait_of(port) === 1'b0) break;
      guard++;
      if (guard > 100) begin
        check("xfer_wait", wait_of(port), 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    drive(port, 1'b0, 1'b1, 1'b1, '0, '0);
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q.size() > 0 || pend_q.size() > 0) && guard < 200) begin
      step();
      guard++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin : main
    int base_acc;
    int base_exp;
    int base_rdv0;
    int base_rdv1;

    // ---------------- reset with both engines requesting ----------------
    reset = 1'b1;
    sdram_bus.waitrequest = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b1, 32'h1000, '0);
    drive(1, 1'b1, 1'b0, 1'b1, 32'h2000, '0);
    repeat (3) begin
      step();
      check("rst_cs",      sdram_bus.chipselect, 0);
      check("rst_read_n",  sdram_bus.read_n, 1);
      check("rst_write_n", sdram_bus.write_n, 1);
      check("rst_addr",    sdram_bus.address, 0);
      check("rst_be",      sdram_bus.byteenable, 0);
      check("rst_wdata",   sdram_bus.writedata, 0);
      check("rst_m0_wait", m0_bus.waitrequest, 1);
      check("rst_m1_wait", m1_bus.waitrequest, 1);
      check("rst_m0_rdv",  m0_bus.readdatavalid, 0);
      check("rst_m1_rdv",  m1_bus.readdatavalid, 0);
      check("rst_err",     err_orphan, 0);
    end
    reset = 1'b0;
    step();   // IDLE sees the tie; last=1 after reset, so m0 wins
    check("first_gnt_cs",   sdram_bus.chipselect, 1);
    check("first_gnt_addr", sdram_bus.address, 32'h1000);
    check("first_m0_wait",  m0_bus.waitrequest, 0);
    check("first_m1_wait",  m1_bus.waitrequest, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 1'b1, '0, '0);
    drive(1, 1'b0, 1'b1, 1'b1, '0, '0);
    wait_drain();

    // ---------------- single write from m0 ----------------
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h100, 16'hBEEF);
    step();
    check("wr_c0_cs",      sdram_bus.chipselect, 0);
    check("wr_c0_m0_wait", m0_bus.waitrequest, 1);
    step();
    check("wr_c1_cs",      sdram_bus.chipselect, 1);
    check("wr_c1_write_n", sdram_bus.write_n, 0);
    check("wr_c1_read_n",  sdram_bus.read_n, 1);
    check("wr_c1_addr",    sdram_bus.address, 32'h100);
    check("wr_c1_wdata",   sdram_bus.writedata, 16'hBEEF);
    check("wr_c1_be",      sdram_bus.byteenable, 2'b11);
    check("wr_c1_m0_wait", m0_bus.waitrequest, 0);
    check("wr_c1_m1_wait", m1_bus.waitrequest, 1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 1'b1, '0, '0);
    step();
    check("wr_c2_cs",      sdram_bus.chipselect, 0);
    check("wr_c2_m0_wait", m0_bus.waitrequest, 1);
    check("wr_c2_m1_wait", m1_bus.waitrequest, 1);
    check("wr_no_push",    exp_q.size(), 0);

    // ---------------- fair alternation, 4 reads each ----------------
    // The only earlier tie went to m0, so the first tie here goes to m1.
    base_acc  = acc_q.size();
    base_rdv0 = rdv0_cnt;
    base_rdv1 = rdv1_cnt;
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 4; i++) xfer(0, 1'b1, 32'h1000 + i, '0);
      for (int i = 0; i < 4; i++) xfer(1, 1'b1, 32'h2000 + i, '0);
    join
    wait_drain();
    check("fair_count", acc_q.size() - base_acc, 8);
    for (int i = 0; i < 8; i++)
      if (base_acc + i < acc_q.size())
        check($sformatf("fair_order%0d", i), acc_q[base_acc + i], (i % 2 == 0) ? 1 : 0);
    check("fair_rdv0", rdv0_cnt - base_rdv0, 4);
    check("fair_rdv1", rdv1_cnt - base_rdv1, 4);

    // ---------------- full owner FIFO ----------------
    auto_ret = 1'b0;
    base_acc = acc_cnt;
    @(posedge clk); #1;
    fork
      for (int i = 0; i < 5; i++) xfer(1, 1'b1, 32'h2100 + i, '0);
      begin
        int guard = 0;
        while (acc_cnt < base_acc + 4 && guard < 100) begin
          step();
          guard++;
        end
        check("full_four_accepted", acc_cnt - base_acc, 4);
        step();   // IDLE after the 4th accept
        repeat (3) begin
          step();
          check("full_blk_cs",      sdram_bus.chipselect, 0);
          check("full_blk_m1_wait", m1_bus.waitrequest, 1);
        end
        release_n = 1;
        step();   // pop cycle: slot freed only at the end of it
        check("full_pop_rdv", m1_bus.readdatavalid, 1);
        check("full_pop_cs",  sdram_bus.chipselect, 0);
        step();
        check("full_next_cs",      sdram_bus.chipselect, 1);
        check("full_next_addr",    sdram_bus.address, 32'h2104);
        check("full_next_m1_wait", m1_bus.waitrequest, 0);
      end
    join
    release_n = 4;
    wait_drain();
    auto_ret = 1'b1;

    // ---------------- slave stall during an m0 read ----------------
    @(posedge clk); #1;
    sdram_bus.waitrequest = 1'b1;
    base_acc = acc_cnt;
    base_exp = exp_q.size();
    fork
      xfer(0, 1'b1, 32'h1010, '0);
      begin
        @(posedge clk); #1;
        xfer(1, 1'b1, 32'h2010, '0);
      end
      begin
        step();   // IDLE cycle
        for (int i = 0; i < 6; i++) begin
          step();
          check("stall_cs",      sdram_bus.chipselect, 1);
          check("stall_addr",    sdram_bus.address, 32'h1010);
          check("stall_read_n",  sdram_bus.read_n, 0);
          check("stall_m0_wait", m0_bus.waitrequest, 1);
          check("stall_m1_wait", m1_bus.waitrequest, 1);
          check("stall_no_push", exp_q.size(), base_exp);
          check("stall_no_acc",  acc_cnt, base_acc);
        end
        @(posedge clk); #1;
        sdram_bus.waitrequest = 1'b0;
      end
    join
    check("stall_after_order0", acc_q[acc_q.size() - 2], 0);
    check("stall_after_order1", acc_q[acc_q.size() - 1], 1);
    wait_drain();

    // ---------------- orphan beat ----------------
    orphan_n = 1;
    step();
    check("orph_m0_rdv", m0_bus.readdatavalid, 0);
    check("orph_m1_rdv", m1_bus.readdatavalid, 0);
    check("orph_err_pre", err_orphan, 0);
    step();
    check("orph_err_set", err_orphan, 1);

    // ---------------- reset with 2 reads outstanding ----------------
    auto_ret = 1'b0;
    @(posedge clk); #1;
    xfer(0, 1'b1, 32'h1020, '0);
    xfer(0, 1'b1, 32'h1021, '0);
    check("mid_pending", pend_q.size(), 2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();   // the arbiter forgets them; the beats are now orphans
    step();
    check("mid_err_clr", err_orphan, 0);
    check("mid_m0_wait", m0_bus.waitrequest, 1);
    release_n = 2;
    step();
    check("late1_m0_rdv", m0_bus.readdatavalid, 0);
    check("late1_m1_rdv", m1_bus.readdatavalid, 0);
    step();
    check("late2_m0_rdv", m0_bus.readdatavalid, 0);
    check("late2_err",    err_orphan, 1);
    step();
    check("late_err_sticky", err_orphan, 1);
    check("late_pend_empty", pend_q.size(), 0);
    auto_ret = 1'b1;

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
